countdown_timer: RTL and testbench

- Loadable down-counter timer with FSM control; the decrementing counterpart of the team's 8-bit up-counter.
- Counts a programmed value down to zero, emits a one-cycle terminal-count pulse, and then either stops in DONE or auto-reloads.
- Used as the interval/timeout source beside the up-counter in the lab top level.

---
 rtl/countdown_timer_if.sv | 14 +
 rtl/countdown_timer.sv | 50 +++++
 tb/tb_countdown_timer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/countdown_timer_if.sv
// countdown_timer_if: control and status signals of the countdown timer
interface countdown_timer_if #(parameter int WIDTH = 8);
  logic             en_i;
  logic             load_i;
  logic             stop_i;
  logic             reload_i;
  logic [WIDTH-1:0] data_i;
  logic [WIDTH-1:0] cnt_o;
  logic             tc_o;
  logic             busy_o;
  logic             done_o;
  modport master (output en_i, load_i, stop_i, reload_i, data_i, input cnt_o, tc_o, busy_o, done_o);
  modport slave (input en_i, load_i, stop_i, reload_i, data_i, output cnt_o, tc_o, busy_o, done_o);
endinterface

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with one-cycle terminal-count pulse and optional auto-reload
module countdown_timer #(parameter int WIDTH = 8) (
  input  logic             clk_i,
  input  logic             rst_i,
  countdown_timer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d, reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             last;
  assign last = cnt_q == WIDTH'(1);
  // next state: load beats stop beats count; terminal count only from RUN at cnt==1
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (bus.load_i) begin
      cnt_d    = bus.data_i;
      reload_d = bus.data_i;
      state_d  = bus.data_i != '0 ? RUN : IDLE;
    end else if (bus.stop_i) begin
      cnt_d   = '0;
      state_d = IDLE;
    end else if (state_q == RUN && bus.en_i) begin
      tc_d    = last;
      cnt_d   = !last ? cnt_q - WIDTH'(1) : bus.reload_i ? reload_q : '0;
      state_d = !last || bus.reload_i ? RUN : DONE;
    end
  end
  // state, count, reload value and pulse registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end
  assign bus.cnt_o  = cnt_q;
  assign bus.tc_o   = tc_q;
  assign bus.busy_o = state_q == RUN;
  assign bus.done_o = state_q == DONE;
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: table-driven directed checks of countdown_timer plus reset and 0xFF sequences
module tb_countdown_timer;
  typedef struct {
    logic       ld, sp, en, rl;
    logic [7:0] d;
    logic [7:0] c;
    logic       t, b, dn;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  vec_t v[$];
  always #5 clk = ~clk;
  countdown_timer_if #(.WIDTH(8)) bus ();
  countdown_timer #(.WIDTH(8)) dut (.clk_i(clk), .rst_i(rst), .bus(bus.slave));
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic chk_all(input string nm, input logic [7:0] c, input logic t, input logic b, input logic dn);
    chk({nm, " cnt"}, bus.cnt_o, c);
    chk({nm, " tc"}, {7'd0, bus.tc_o}, {7'd0, t});
    chk({nm, " busy"}, {7'd0, bus.busy_o}, {7'd0, b});
    chk({nm, " done"}, {7'd0, bus.done_o}, {7'd0, dn});
  endtask
  task automatic drive(input logic ld, input logic sp, input logic en, input logic rl, input logic [7:0] d);
    bus.load_i   = ld;
    bus.stop_i   = sp;
    bus.en_i     = en;
    bus.reload_i = rl;
    bus.data_i   = d;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic add(input logic ld, input logic sp, input logic en, input logic rl, input logic [7:0] d,
                     input logic [7:0] c, input logic t, input logic b, input logic dn);
    vec_t x;
    x.ld = ld; x.sp = sp; x.en = en; x.rl = rl; x.d = d;
    x.c = c; x.t = t; x.b = b; x.dn = dn;
    v.push_back(x);
  endtask
  initial begin
    int n;
    drive(0, 0, 0, 0, 8'h00);
    // one-shot load 5
    add(1, 0, 1, 0, 8'h05, 8'h05, 0, 1, 0);
    add(0, 0, 1, 0, 8'h00, 8'h04, 0, 1, 0);
    add(0, 0, 1, 0, 8'h00, 8'h03, 0, 1, 0);
    add(0, 0, 1, 0, 8'h00, 8'h02, 0, 1, 0);
    add(0, 0, 1, 0, 8'h00, 8'h01, 0, 1, 0);
    add(0, 0, 1, 0, 8'h00, 8'h00, 1, 0, 1);
    add(0, 0, 1, 0, 8'h00, 8'h00, 0, 0, 1);
    add(0, 0, 1, 1, 8'h00, 8'h00, 0, 0, 1);
    // auto-reload load 3, 12 enabled cycles
    add(1, 0, 1, 1, 8'h03, 8'h03, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      add(0, 0, 1, 1, 8'h00, 8'h02, 0, 1, 0);
      add(0, 0, 1, 1, 8'h00, 8'h01, 0, 1, 0);
      add(0, 0, 1, 1, 8'h00, 8'h03, 1, 1, 0);
    end
    // enable gating load 4
    add(1, 0, 1, 0, 8'h04, 8'h04, 0, 1, 0);
    add(0, 0, 1, 0, 8'h00, 8'h03, 0, 1, 0);
    add(0, 0, 0, 0, 8'h00, 8'h03, 0, 1, 0);
    add(0, 0, 0, 0, 8'h00, 8'h03, 0, 1, 0);
    add(0, 0, 1, 0, 8'h00, 8'h02, 0, 1, 0);
    add(0, 0, 1, 0, 8'h00, 8'h01, 0, 1, 0);
    add(0, 0, 1, 0, 8'h00, 8'h00, 1, 0, 1);
    // load beats terminal count
    add(1, 0, 1, 0, 8'h02, 8'h02, 0, 1, 0);
    add(0, 0, 1, 0, 8'h00, 8'h01, 0, 1, 0);
    add(1, 0, 1, 0, 8'h0A, 8'h0A, 0, 1, 0);
    // stop beats terminal count
    add(1, 0, 1, 0, 8'h01, 8'h01, 0, 1, 0);
    add(0, 1, 1, 0, 8'h00, 8'h00, 0, 0, 0);
    add(0, 0, 1, 0, 8'h00, 8'h00, 0, 0, 0);
    // load zero stays idle
    add(1, 0, 1, 0, 8'h00, 8'h00, 0, 0, 0);
    add(0, 0, 1, 1, 8'h00, 8'h00, 0, 0, 0);
    // N=1 auto-reload pulses every cycle, then enable gating
    add(1, 0, 1, 1, 8'h01, 8'h01, 0, 1, 0);
    add(0, 0, 1, 1, 8'h00, 8'h01, 1, 1, 0);
    add(0, 0, 1, 1, 8'h00, 8'h01, 1, 1, 0);
    add(0, 0, 0, 1, 8'h00, 8'h01, 0, 1, 0);
    // stop out of RUN with count left
    add(1, 0, 0, 0, 8'h09, 8'h09, 0, 1, 0);
    add(0, 1, 1, 0, 8'h00, 8'h00, 0, 0, 0);
    #1;
    chk_all("reset", 8'h00, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step();
    chk_all("post-reset idle", 8'h00, 0, 0, 0);
    foreach (v[i]) begin
      drive(v[i].ld, v[i].sp, v[i].en, v[i].rl, v[i].d);
      step();
      chk_all($sformatf("vec%0d", i), v[i].c, v[i].t, v[i].b, v[i].dn);
    end
    // async reset in the middle of a run
    drive(1, 0, 0, 0, 8'h37);
    step();
    drive(0, 0, 0, 0, 8'h00);
    chk_all("pre-rst run", 8'h37, 0, 1, 0);
    #3 rst = 1'b1;
    #1;
    chk_all("async rst", 8'h00, 0, 0, 0);
    step();
    #2 rst = 1'b0;
    drive(0, 0, 1, 1, 8'h00);
    step();
    step();
    chk_all("after rst idle", 8'h00, 0, 0, 0);
    // 0xFF one-shot: pulse after exactly 255 enabled cycles
    drive(1, 0, 1, 0, 8'hFF);
    step();
    drive(0, 0, 1, 0, 8'h00);
    chk_all("load ff", 8'hFF, 0, 1, 0);
    n = 0;
    while (n < 300 && bus.tc_o !== 1'b1) begin
      step();
      n++;
    end
    chk("ff latency", n[7:0], 8'hFF);
    chk("ff latency hi", {7'd0, n > 255}, 8'h00);
    chk_all("ff end", 8'h00, 1, 0, 1);
    step();
    chk_all("ff done hold", 8'h00, 0, 0, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
